// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, funct3 encodings,
// FSM states and mstatus field positions.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [2:0] {
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } funct3_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/riscv_csrbus_if.sv
// CSR access bus between the core's execute stage (master) and the CSR file (slave).
interface riscv_csrbus_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic [2:0]      funct3;
    logic [11:0]     csr;
    logic [4:0]      rs1;
    logic [XLEN-1:0] rs1_value;
    logic            ready;
    logic [XLEN-1:0] rd_value;
    logic            error;

    modport master (
        output valid, funct3, csr, rs1, rs1_value,
        input  ready, rd_value, error
    );

    modport slave (
        input  valid, funct3, csr, rs1, rs1_value,
        output ready, rd_value, error
    );
endinterface

// File: rtl/riscv_csr_counter.sv
// 64-bit free-running counter with per-half write ports; a write in a cycle
// suppresses that cycle's increment and leaves the unwritten half untouched.
module riscv_csr_counter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata_lo,
    input  logic [31:0] i_wdata_hi,
    output logic [63:0] o_count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_we_lo || i_we_hi) begin
            if (i_we_lo) count_d[31:0]  = i_wdata_lo;
            if (i_we_hi) count_d[63:32] = i_wdata_hi;
        end else if (i_inc) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign o_count = count_q;

endmodule

// File: rtl/riscv_csr_unit.sv
// Machine-mode CSR file: decodes Zicsr accesses from the CSR bus, returns the old
// value one cycle after acceptance and commits the read-modify-write at acceptance.
module riscv_csr_unit
    import riscv_csr_pkg::*;
#(
    parameter int          XLEN = 32,
    parameter logic [31:0] MISA = 32'h4000_0100
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    riscv_csrbus_if.slave   csrbus_if,
    input  logic            i_instret,
    output logic            o_mie,
    output logic [XLEN-1:0] o_mtvec,
    output logic [XLEN-1:0] o_mepc
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            err_q, err_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    logic [63:0]     mcycle, minstret;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [63:0]     new_ext;
    logic            f3_ok;
    logic            impl;
    logic            write_req;
    logic            acc_err;
    logic            accept;
    logic            csr_we;

    always_comb begin
        mstatus_rd                                = '0;
        mstatus_rd[MSTATUS_MIE]                   = mie_q;
        mstatus_rd[MSTATUS_MPIE]                  = mpie_q;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Decode and read-modify-write value of the request currently on the bus.
    always_comb begin
        operand   = csrbus_if.funct3[2] ? XLEN'(csrbus_if.rs1) : csrbus_if.rs1_value;
        impl      = 1'b1;
        old_val   = '0;
        case (csrbus_if.csr)
            CSR_MSTATUS:   old_val = mstatus_rd;
            CSR_MISA:      old_val = XLEN'(MISA);
            CSR_MTVEC:     old_val = mtvec_q;
            CSR_MSCRATCH:  old_val = mscratch_q;
            CSR_MEPC:      old_val = mepc_q;
            CSR_MCAUSE:    old_val = mcause_q;
            CSR_MCYCLE:    old_val = XLEN'(mcycle);
            CSR_MINSTRET:  old_val = XLEN'(minstret);
            CSR_MCYCLEH: begin
                impl    = (XLEN == 32);
                old_val = XLEN'(mcycle[63:32]);
            end
            CSR_MINSTRETH: begin
                impl    = (XLEN == 32);
                old_val = XLEN'(minstret[63:32]);
            end
            CSR_MHARTID:   old_val = '0;
            default:       impl    = 1'b0;
        endcase

        f3_ok   = 1'b1;
        new_val = old_val;
        case (funct3_e'(csrbus_if.funct3))
            F3_CSRRW, F3_CSRRWI: new_val = operand;
            F3_CSRRS, F3_CSRRSI: new_val = old_val | operand;
            F3_CSRRC, F3_CSRRCI: new_val = old_val & ~operand;
            default:             f3_ok   = 1'b0;
        endcase

        write_req = (csrbus_if.funct3[1:0] == 2'b01) || (csrbus_if.rs1 != 5'd0);
        acc_err   = !f3_ok || !impl || (write_req && (csrbus_if.csr[11:10] == 2'b11));
        accept    = (state_q == ST_IDLE) && csrbus_if.valid;
        csr_we    = accept && !acc_err && write_req;
        new_ext   = 64'(new_val);
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        err_d      = err_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        case (state_q)
            ST_IDLE: begin
                if (csrbus_if.valid) begin
                    state_d = ST_RESP;
                    rd_d    = acc_err ? '0 : old_val;
                    err_d   = acc_err;
                end
                if (csr_we) begin
                    case (csrbus_if.csr)
                        CSR_MSTATUS: begin
                            mie_d  = new_val[MSTATUS_MIE];
                            mpie_d = new_val[MSTATUS_MPIE];
                        end
                        CSR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 1'b0, new_val[0]};
                        CSR_MSCRATCH: mscratch_d = new_val;
                        CSR_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
                        CSR_MCAUSE:   mcause_d   = new_val;
                        default: ;
                    endcase
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rd_q       <= '0;
            err_q      <= 1'b0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    // On RV64 the low-word address covers the whole counter.
    logic cyc_we_lo, cyc_we_hi, ins_we_lo, ins_we_hi;
    logic [31:0] cnt_wdata_hi;

    assign cyc_we_lo    = csr_we && (csrbus_if.csr == CSR_MCYCLE);
    assign cyc_we_hi    = csr_we && ((csrbus_if.csr == CSR_MCYCLEH) ||
                                     ((XLEN == 64) && (csrbus_if.csr == CSR_MCYCLE)));
    assign ins_we_lo    = csr_we && (csrbus_if.csr == CSR_MINSTRET);
    assign ins_we_hi    = csr_we && ((csrbus_if.csr == CSR_MINSTRETH) ||
                                     ((XLEN == 64) && (csrbus_if.csr == CSR_MINSTRET)));
    assign cnt_wdata_hi = (XLEN == 64) ? new_ext[63:32] : new_ext[31:0];

    riscv_csr_counter u_mcycle (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc      (1'b1),
        .i_we_lo    (cyc_we_lo),
        .i_we_hi    (cyc_we_hi),
        .i_wdata_lo (new_ext[31:0]),
        .i_wdata_hi (cnt_wdata_hi),
        .o_count    (mcycle)
    );

    riscv_csr_counter u_minstret (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc      (i_instret),
        .i_we_lo    (ins_we_lo),
        .i_we_hi    (ins_we_hi),
        .i_wdata_lo (new_ext[31:0]),
        .i_wdata_hi (cnt_wdata_hi),
        .o_count    (minstret)
    );

    assign csrbus_if.ready    = (state_q == ST_RESP);
    assign csrbus_if.rd_value = rd_q;
    assign csrbus_if.error    = err_q;
    assign o_mie              = mie_q;
    assign o_mtvec            = mtvec_q;
    assign o_mepc             = mepc_q;

endmodule

// File: tb/tb_riscv_csr_unit.sv
// Self-checking bench for riscv_csr_unit: directed scenarios plus randomized
// accesses checked against an architectural CSR model kept in the bench.
module tb_riscv_csr_unit;

    localparam int XLEN = 32;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_instret;
    logic            o_mie;
    logic [XLEN-1:0] o_mtvec;
    logic [XLEN-1:0] o_mepc;

    riscv_csrbus_if #(.XLEN(XLEN)) bus ();

    riscv_csr_unit #(.XLEN(XLEN), .MISA(32'h4000_0100)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .csrbus_if (bus),
        .i_instret (i_instret),
        .o_mie     (o_mie),
        .o_mtvec   (o_mtvec),
        .o_mepc    (o_mepc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses_left = 0;
    bit rand_mode = 0;

    // Architectural model state
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle, m_instret;
    logic        req_pending;
    logic [2:0]  r_f3;
    logic [11:0] r_csr;
    logic [4:0]  r_rs1;
    logic [31:0] r_val;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        cyc_w, ins_w;

    function automatic void model_step(output logic cw, output logic iw);
        logic [31:0] old, op, nv;
        logic impl, wr, bad;
        impl = 1'b1;
        old  = 32'd0;
        cw   = 1'b0;
        iw   = 1'b0;
        case (r_csr)
            12'h300: old = 32'h0000_1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: old = 32'h4000_0100;
            12'h305: old = m_mtvec;
            12'h340: old = m_mscratch;
            12'h341: old = m_mepc;
            12'h342: old = m_mcause;
            12'hB00: old = m_cycle[31:0];
            12'hB02: old = m_instret[31:0];
            12'hB80: old = m_cycle[63:32];
            12'hB82: old = m_instret[63:32];
            12'hF14: old = 32'd0;
            default: impl = 1'b0;
        endcase
        op  = r_f3[2] ? {27'd0, r_rs1} : r_val;
        wr  = (r_f3[1:0] == 2'b01) || (r_rs1 != 5'd0);
        bad = (r_f3[1:0] == 2'b00) || !impl || (wr && r_csr[11:10] == 2'b11);
        if (bad) begin
            exp_rd  = 32'd0;
            exp_err = 1'b1;
        end else begin
            exp_rd  = old;
            exp_err = 1'b0;
            if (wr) begin
                if (r_f3[1:0] == 2'b01)      nv = op;
                else if (r_f3[1:0] == 2'b10) nv = old | op;
                else                         nv = old & ~op;
                case (r_csr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec    = nv & 32'hFFFF_FFFD;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
                    12'h342: m_mcause   = nv;
                    12'hB00: begin m_cycle[31:0]    = nv; cw = 1'b1; end
                    12'hB80: begin m_cycle[63:32]   = nv; cw = 1'b1; end
                    12'hB02: begin m_instret[31:0]  = nv; iw = 1'b1; end
                    12'hB82: begin m_instret[63:32] = nv; iw = 1'b1; end
                    default: ;
                endcase
            end
        end
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_mie = 0; m_mpie = 0;
            m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_cycle = 0; m_instret = 0;
            req_pending = 0; exp_rd = 0; exp_err = 0;
        end else begin
            cyc_w = 1'b0;
            ins_w = 1'b0;
            if (req_pending) begin
                model_step(cyc_w, ins_w);
                req_pending = 1'b0;
            end
            if (!cyc_w) m_cycle = m_cycle + 64'd1;
            if (i_instret && !ins_w) m_instret = m_instret + 64'd1;
        end
    end

    function automatic logic pick_instret();
        if (pulses_left > 0) begin
            pulses_left--;
            return 1'b1;
        end
        return rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_instret = pick_instret();
        end
    endtask

    // One bus transaction at full rate; compares the response against the model.
    task automatic do_access(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                             input logic [31:0] v, output logic [31:0] rd, output logic er);
        @(negedge i_clk);
        i_instret = pick_instret();
        n_checks++;
        if (bus.ready !== 1'b0) $display("FAIL ready_before_accept: got %b want 0", bus.ready);
        else n_pass++;
        bus.funct3 = f3; bus.csr = a; bus.rs1 = r1; bus.rs1_value = v; bus.valid = 1'b1;
        r_f3 = f3; r_csr = a; r_rs1 = r1; r_val = v; req_pending = 1'b1;
        @(negedge i_clk);
        i_instret = pick_instret();
        bus.valid = 1'b0;
        rd = bus.rd_value;
        er = bus.error;
        n_checks++;
        if (bus.ready !== 1'b1) $display("FAIL ready_resp csr=%h: got %b want 1", a, bus.ready);
        else n_pass++;
        n_checks++;
        if (bus.rd_value !== exp_rd)
            $display("FAIL rd_value csr=%h f3=%b: got %h want %h", a, f3, bus.rd_value, exp_rd);
        else n_pass++;
        n_checks++;
        if (bus.error !== exp_err)
            $display("FAIL error csr=%h f3=%b: got %b want %b", a, f3, bus.error, exp_err);
        else n_pass++;
        n_checks++;
        if (o_mie !== m_mie || o_mtvec !== m_mtvec || o_mepc !== m_mepc)
            $display("FAIL trap_outputs: got mie=%b mtvec=%h mepc=%h want mie=%b mtvec=%h mepc=%h",
                     o_mie, o_mtvec, o_mepc, m_mie, m_mtvec, m_mepc);
        else n_pass++;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_instret = 1'b0;
        bus.valid = 1'b0; bus.funct3 = 3'd0; bus.csr = 12'd0; bus.rs1 = 5'd0; bus.rs1_value = '0;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (bus.ready !== 1'b0 || bus.rd_value !== 32'd0 || bus.error !== 1'b0)
            $display("FAIL reset_bus: got ready=%b rd=%h err=%b want 0/0/0",
                     bus.ready, bus.rd_value, bus.error);
        else n_pass++;
        n_checks++;
        if (o_mie !== 1'b0 || o_mtvec !== 32'd0 || o_mepc !== 32'd0)
            $display("FAIL reset_outputs: got mie=%b mtvec=%h mepc=%h want 0", o_mie, o_mtvec, o_mepc);
        else n_pass++;
        i_rst_n = 1'b1;
    endtask

    task automatic test_mscratch();
        logic [31:0] rd; logic er;
        do_access(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b0) $display("FAIL mscratch_rw: got %h/%b want 00000000/0", rd, er);
        else n_pass++;
        do_access(3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, rd, er);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL mscratch_read: got %h want deadbeef", rd);
        else n_pass++;
        do_access(3'b011, 12'h340, 5'd0, 32'hFFFF_FFFF, rd, er);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL mscratch_unchanged: got %h want deadbeef", rd);
        else n_pass++;
    endtask

    task automatic test_mstatus();
        logic [31:0] rd; logic er;
        do_access(3'b110, 12'h300, 5'd8, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'h0000_1800 || o_mie !== 1'b1)
            $display("FAIL mstatus_set: got rd=%h mie=%b want 00001800/1", rd, o_mie);
        else n_pass++;
        do_access(3'b111, 12'h300, 5'd8, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'h0000_1808 || o_mie !== 1'b0)
            $display("FAIL mstatus_clear: got rd=%h mie=%b want 00001808/0", rd, o_mie);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er;
        do_access(3'b001, 12'h7C0, 5'd1, 32'h1234_5678, rd, er);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL err_unimpl: got %h/%b want 00000000/1", rd, er);
        else n_pass++;
        do_access(3'b001, 12'hF14, 5'd1, 32'h1234_5678, rd, er);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL err_readonly: got %h/%b want 00000000/1", rd, er);
        else n_pass++;
        do_access(3'b100, 12'h340, 5'd5, 32'h1234_5678, rd, er);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0) $display("FAIL err_funct3: got %h/%b want 00000000/1", rd, er);
        else n_pass++;
        do_access(3'b010, 12'h340, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL err_no_side_effect: got %h want deadbeef", rd);
        else n_pass++;
        do_access(3'b001, 12'h301, 5'd1, 32'd0, rd, er);
        do_access(3'b010, 12'h301, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'h4000_0100 || er !== 1'b0) $display("FAIL misa_ro: got %h/%b want 40000100/0", rd, er);
        else n_pass++;
    endtask

    task automatic test_counters();
        logic [31:0] rd; logic er;
        pulses_left = 5;
        idle(8);
        do_access(3'b010, 12'hB02, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'd5) $display("FAIL minstret_count: got %0d want 5", rd);
        else n_pass++;
        do_access(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, rd, er);
        do_access(3'b010, 12'hB80, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'd1) $display("FAIL mcycleh_carry: got %h want 00000001", rd);
        else n_pass++;
        pulses_left = 1;
        do_access(3'b001, 12'hB02, 5'd1, 32'd100, rd, er);
        do_access(3'b010, 12'hB02, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'd100) $display("FAIL minstret_write_wins: got %0d want 100", rd);
        else n_pass++;
        do_access(3'b001, 12'hB00, 5'd1, 32'h0000_1234, rd, er);
        do_access(3'b010, 12'hB00, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'h0000_1235) $display("FAIL mcycle_write_wins: got %h want 00001235", rd);
        else n_pass++;
    endtask

    task automatic test_warl();
        logic [31:0] rd; logic er;
        do_access(3'b001, 12'h341, 5'd1, 32'h8000_0003, rd, er);
        do_access(3'b010, 12'h341, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'h8000_0000 || o_mepc !== 32'h8000_0000)
            $display("FAIL mepc_warl: got rd=%h o_mepc=%h want 80000000", rd, o_mepc);
        else n_pass++;
        do_access(3'b001, 12'h305, 5'd1, 32'h8000_0002, rd, er);
        do_access(3'b010, 12'h305, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'h8000_0000 || o_mtvec !== 32'h8000_0000)
            $display("FAIL mtvec_warl: got rd=%h o_mtvec=%h want 80000000", rd, o_mtvec);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                    12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'hC00, 12'h344};
        logic [31:0] rd; logic er;
        logic [4:0]  r1;
        rand_mode = 1;
        for (int i = 0; i < 200; i++) begin
            r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_access(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 13)], r1, $urandom, rd, er);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_mode = 0;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; logic er;
        do_access(3'b001, 12'h340, 5'd1, 32'hA5A5_5A5A, rd, er);
        @(negedge i_clk);
        i_instret = 1'b0;
        bus.funct3 = 3'b010; bus.csr = 12'h340; bus.rs1 = 5'd0; bus.rs1_value = '0; bus.valid = 1'b1;
        r_f3 = 3'b010; r_csr = 12'h340; r_rs1 = 5'd0; r_val = '0; req_pending = 1'b1;
        @(posedge i_clk);
        #2;
        n_checks++;
        if (bus.ready !== 1'b1) $display("FAIL ready_before_reset: got %b want 1", bus.ready);
        else n_pass++;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ready !== 1'b0) $display("FAIL ready_async_drop: got %b want 0", bus.ready);
        else n_pass++;
        bus.valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        do_access(3'b010, 12'h340, 5'd0, 32'd0, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b0) $display("FAIL mscratch_after_reset: got %h/%b want 00000000/0", rd, er);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mscratch();
        test_mstatus();
        test_errors();
        test_counters();
        test_warl();
        test_random();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
